// File: rtl/pong_pkg.sv
// pong_pkg: shared score width and game-state encoding for the Pong datapath
package pong_pkg;
    localparam int SCORE_W = 4;
    typedef enum logic [1:0] {IDLE, PLAY, POINT, OVER} game_state_t;
endpackage

// File: rtl/score_keeper_if.sv
// score_keeper_if: playfield events in, score/game controls out of the score keeper
interface score_keeper_if;
    import pong_pkg::*;
    logic               frame;
    logic               start;
    logic               miss_l;
    logic               miss_r;
    logic [SCORE_W-1:0] score_l;
    logic [SCORE_W-1:0] score_r;
    logic               playing;
    logic               point;
    logic               game_over;
    logic               winner;
    logic               serve_dir;
    modport master (
        output frame, start, miss_l, miss_r,
        input  score_l, score_r, playing, point, game_over, winner, serve_dir
    );
    modport slave (
        input  frame, start, miss_l, miss_r,
        output score_l, score_r, playing, point, game_over, winner, serve_dir
    );
endinterface

// File: rtl/edge_rise.sv
// edge_rise: one-register rising-edge detector for level miss inputs
module edge_rise (
    input  logic clk_pix,
    input  logic rst_pix,
    input  logic x,
    output logic rise
);
    logic x_q;
    // remember the previous sample so a held level yields a single pulse
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) x_q <= 1'b0;
        else         x_q <= x;
    end
    assign rise = x & ~x_q;
endmodule

// File: rtl/score_keeper.sv
// score_keeper: Pong game FSM and 0..WIN_SCORE scores; SCORE_AUTOSERVE_EN makes POINT->PLAY automatic
module score_keeper
    import pong_pkg::*;
#(
    parameter int WIN_SCORE    = 9,
    parameter int PAUSE_FRAMES = 60
) (
    input  logic           clk_pix,
    input  logic           rst_pix,
    score_keeper_if.slave  bus
);
    localparam int CNT_W = (PAUSE_FRAMES > 0) ? $clog2(PAUSE_FRAMES + 1) : 1;

    game_state_t        state_q, state_d;
    logic [SCORE_W-1:0] score_l_q, score_l_d, score_r_q, score_r_d, inc_l, inc_r;
    logic               point_q, point_d, winner_q, winner_d, serve_q, serve_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rise_l, rise_r;
`ifndef SCORE_AUTOSERVE_EN
    logic               ready_q, ready_d;
`endif

    edge_rise u_edge_l (.clk_pix(clk_pix), .rst_pix(rst_pix), .x(bus.miss_l), .rise(rise_l));
    edge_rise u_edge_r (.clk_pix(clk_pix), .rst_pix(rst_pix), .x(bus.miss_r), .rise(rise_r));

    // next-state, scoring and pause countdown
    always_comb begin
        state_d   = state_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        point_d   = 1'b0;
        winner_d  = winner_q;
        serve_d   = serve_q;
        cnt_d     = cnt_q;
        inc_l     = score_l_q + 1'b1;
        inc_r     = score_r_q + 1'b1;
`ifndef SCORE_AUTOSERVE_EN
        // a start is only honoured from the cycle after the pause has run out
        ready_d   = (state_q == POINT) && (cnt_q == '0);
`endif
        case (state_q)
            IDLE, OVER: begin
                if (bus.start) begin
                    state_d   = PLAY;
                    score_l_d = '0;
                    score_r_d = '0;
                end
            end
            PLAY: begin
                if (rise_l && rise_r) begin
                    state_d = POINT;
                    cnt_d   = CNT_W'(PAUSE_FRAMES);
                end else if (rise_l) begin
                    score_r_d = inc_r;
                    point_d   = 1'b1;
                    if (inc_r == SCORE_W'(WIN_SCORE)) begin
                        state_d  = OVER;
                        winner_d = 1'b1;
                    end else begin
                        state_d = POINT;
                        serve_d = 1'b0;
                        cnt_d   = CNT_W'(PAUSE_FRAMES);
                    end
                end else if (rise_r) begin
                    score_l_d = inc_l;
                    point_d   = 1'b1;
                    if (inc_l == SCORE_W'(WIN_SCORE)) begin
                        state_d  = OVER;
                        winner_d = 1'b0;
                    end else begin
                        state_d = POINT;
                        serve_d = 1'b1;
                        cnt_d   = CNT_W'(PAUSE_FRAMES);
                    end
                end
            end
            POINT: begin
                if (cnt_q != '0) begin
                    if (bus.frame) cnt_d = cnt_q - 1'b1;
                end
`ifdef SCORE_AUTOSERVE_EN
                else state_d = PLAY;
`else
                else if (ready_q && bus.start) state_d = PLAY;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // all game state and outputs are registered
    always_ff @(posedge clk_pix or posedge rst_pix) begin
        if (rst_pix) begin
            state_q   <= IDLE;
            score_l_q <= '0;
            score_r_q <= '0;
            point_q   <= 1'b0;
            winner_q  <= 1'b0;
            serve_q   <= 1'b0;
            cnt_q     <= '0;
`ifndef SCORE_AUTOSERVE_EN
            ready_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            point_q   <= point_d;
            winner_q  <= winner_d;
            serve_q   <= serve_d;
            cnt_q     <= cnt_d;
`ifndef SCORE_AUTOSERVE_EN
            ready_q   <= ready_d;
`endif
        end
    end

    assign bus.score_l   = score_l_q;
    assign bus.score_r   = score_r_q;
    assign bus.playing   = (state_q == PLAY);
    assign bus.point     = point_q;
    assign bus.game_over = (state_q == OVER);
    assign bus.winner    = winner_q;
    assign bus.serve_dir = serve_q;
endmodule
